// File: rtl/inst_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// inst_fetch_unit_if
// Bundles the fetch unit's external buses: the instruction-cache request/ack
// handshake, the branch redirect input and the dequeue side of the
// fetched-instruction FIFO.
//
// Ports/signals (seen from the fetch unit, modport master):
//   pc_icache_ce   out  fetch request valid to the instruction cache
//   icache_addr    out  fetch address, held while ce=1 until acked
//   icache_enable  in   cache ack, icache_inst valid this cycle
//   icache_inst    in   fetched instruction
//   redirect_valid in   one-cycle branch/jump redirect pulse
//   redirect_pc    in   redirect target
//   deq_valid      out  FIFO head valid
//   deq_ready      in   consumer pops head when deq_valid & deq_ready
//   deq_inst       out  head instruction
//   deq_pc         out  PC of head instruction
//   queue_count    out  FIFO occupancy
// The slave modport is the environment side (cache + decode stage).
// ---------------------------------------------------------------------------
interface inst_fetch_unit_if #(
   parameter int INST_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 32,
   parameter int QUEUE_DEPTH = 8
);
   logic                           pc_icache_ce;
   logic [ADDR_WIDTH-1:0]          icache_addr;
   logic                           icache_enable;
   logic [INST_WIDTH-1:0]          icache_inst;
   logic                           redirect_valid;
   logic [ADDR_WIDTH-1:0]          redirect_pc;
   logic                           deq_valid;
   logic                           deq_ready;
   logic [INST_WIDTH-1:0]          deq_inst;
   logic [ADDR_WIDTH-1:0]          deq_pc;
   logic [$clog2(QUEUE_DEPTH):0]   queue_count;

   modport master (
      output pc_icache_ce, icache_addr, deq_valid, deq_inst, deq_pc, queue_count,
      input  icache_enable, icache_inst, redirect_valid, redirect_pc, deq_ready
   );

   modport slave (
      input  pc_icache_ce, icache_addr, deq_valid, deq_inst, deq_pc, queue_count,
      output icache_enable, icache_inst, redirect_valid, redirect_pc, deq_ready
   );
endinterface

// File: rtl/inst_fetch_unit.sv
// ---------------------------------------------------------------------------
// inst_fetch_unit
// CPU-side initiator of the instruction-cache fetch protocol. Owns the PC,
// issues one request at a time to the cache, and buffers every accepted
// instruction together with its PC in a circular FIFO for decode/issue.
// A redirect flushes the FIFO, discards any same-cycle ack and restarts
// fetching at the target. Fetch stalls while the FIFO is full.
//
// Ports:
//   clk   in   clock, all state on the rising edge
//   rst   in   asynchronous reset, active-low
//   bus   master modport of inst_fetch_unit_if (cache, redirect, dequeue)
// ---------------------------------------------------------------------------
module inst_fetch_unit #(
   parameter int                    INST_WIDTH  = 32,
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    QUEUE_DEPTH = 8,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
   parameter int                    PC_STEP     = 4
) (
   input  logic                clk,
   input  logic                rst,
   inst_fetch_unit_if.master   bus
);

   localparam int PTR_W = $clog2(QUEUE_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0]      FULL_COUNT = CNT_W'(QUEUE_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] PC_INC     = ADDR_WIDTH'(PC_STEP);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      STALL
   } state_t;

   state_t                  state;
   state_t                  state_next;
   logic [ADDR_WIDTH-1:0]   pc;
   logic [ADDR_WIDTH-1:0]   pc_next;
   logic [CNT_W-1:0]        count;
   logic [CNT_W-1:0]        count_next;
   logic [PTR_W-1:0]        wr_ptr;
   logic [PTR_W-1:0]        rd_ptr;
   logic [INST_WIDTH-1:0]   inst_mem [QUEUE_DEPTH];
   logic [ADDR_WIDTH-1:0]   pc_mem   [QUEUE_DEPTH];
   logic                    flush;
   logic                    ack;
   logic                    push;
   logic                    pop;
   logic                    head_valid;

   // A redirect overrides everything in its cycle: the ack (if any) and any
   // pop are dropped so the flushed queue really ends up empty.
   assign flush      = bus.redirect_valid;
   assign head_valid = (count != '0);
   assign ack        = (state == REQ) && bus.icache_enable;
   assign push       = ack && !flush;
   assign pop        = bus.deq_ready && head_valid && !flush;

   // Occupancy after this cycle's push/pop; also drives the stall decision so
   // fetch stops exactly when the last free slot is taken.
   always_comb begin
      count_next = count;
      if (flush) begin
         count_next = '0;
      end else begin
         case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
         endcase
      end
   end

   // Next-state and next-PC logic. The PC only advances on an accepted ack,
   // so the address stays stable for however long the cache takes.
   always_comb begin
      state_next = state;
      pc_next    = pc;
      if (flush) begin
         state_next = REQ;
         pc_next    = bus.redirect_pc;
      end else begin
         case (state)
            IDLE: begin
               state_next = REQ;
            end
            REQ: begin
               if (push) begin
                  pc_next = pc + PC_INC;
               end
               if (count_next == FULL_COUNT) begin
                  state_next = STALL;
               end
            end
            STALL: begin
               if (count_next != FULL_COUNT) begin
                  state_next = REQ;
               end
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   // Control state: FSM, PC, occupancy and FIFO pointers. A flush rewinds
   // both pointers so the queue restarts from a clean slot.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         pc     <= RESET_PC;
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         state <= state_next;
         pc    <= pc_next;
         count <= count_next;
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push) begin
               wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
               rd_ptr <= rd_ptr + 1'b1;
            end
         end
      end
   end

   // FIFO storage carries no reset; the head outputs are gated by occupancy
   // so stale entries are never visible.
   always_ff @(posedge clk) begin
      if (push) begin
         inst_mem[wr_ptr] <= bus.icache_inst;
         pc_mem[wr_ptr]   <= pc;
      end
   end

   // Request is a pure decode of the state register, so an async reset drops
   // ce immediately.
   assign bus.pc_icache_ce = (state == REQ);
   assign bus.icache_addr  = pc;
   assign bus.deq_valid    = head_valid;
   assign bus.deq_inst     = head_valid ? inst_mem[rd_ptr] : '0;
   assign bus.deq_pc       = head_valid ? pc_mem[rd_ptr] : '0;
   assign bus.queue_count  = count;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch_unit
// Self-checking bench for inst_fetch_unit. A cache model answers requests
// after a programmable latency with an instruction derived from the address.
// A negedge scoreboard tracks the expected PC and every accepted fetch and
// checks each pop against it; scenario tasks check cycle-specific behaviour.
// ---------------------------------------------------------------------------
module tb_inst_fetch_unit;

   logic clk;
   logic rst;
   int   tests_run;
   int   tests_failed;

   // Cache model controls
   logic cache_on;
   int   latency;
   int   wait_cnt;

   // Scoreboard entries are {inst, pc}
   logic [63:0] sb [$];
   logic [31:0] exp_pc;

   inst_fetch_unit_if #(.INST_WIDTH(32), .ADDR_WIDTH(32), .QUEUE_DEPTH(8)) bus ();

   inst_fetch_unit #(
      .INST_WIDTH(32), .ADDR_WIDTH(32), .QUEUE_DEPTH(8),
      .RESET_PC(32'h0), .PC_STEP(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   // Cache model: acks after `latency` waiting cycles, restarting the count
   // whenever the request is accepted, withdrawn or re-addressed.
   always_comb begin
      bus.icache_enable = bus.pc_icache_ce && cache_on && (wait_cnt >= latency);
      bus.icache_inst   = inst_of(bus.icache_addr);
   end

   always @(posedge clk) begin
      if (!rst || !bus.pc_icache_ce || bus.icache_enable || bus.redirect_valid)
         wait_cnt <= 0;
      else
         wait_cnt <= wait_cnt + 1;
   end

   // Scoreboard: sampled mid-cycle, it predicts what the coming rising edge
   // does (pop, then push of the accepted fetch, or a redirect flush).
   always @(negedge clk) begin
      if (!rst) begin
         sb.delete();
         exp_pc = 32'h0;
      end else begin
         if (bus.pc_icache_ce) begin
            tests_run++;
            if (bus.icache_addr !== exp_pc) begin
               tests_failed++;
               $display("[TB] FAIL sb_addr: got %h expected %h", bus.icache_addr, exp_pc);
            end
         end
         tests_run++;
         if (bus.queue_count !== 4'(sb.size())) begin
            tests_failed++;
            $display("[TB] FAIL sb_count: got %0d expected %0d", bus.queue_count, sb.size());
         end
         if (bus.redirect_valid) begin
            sb.delete();
            exp_pc = bus.redirect_pc;
         end else begin
            if (bus.deq_valid && bus.deq_ready) begin
               tests_run++;
               if (sb.size() == 0) begin
                  tests_failed++;
                  $display("[TB] FAIL sb_pop: unexpected pop pc=%h", bus.deq_pc);
               end else if ({bus.deq_inst, bus.deq_pc} !== sb[0]) begin
                  tests_failed++;
                  $display("[TB] FAIL sb_pop: got inst=%h pc=%h expected inst=%h pc=%h",
                           bus.deq_inst, bus.deq_pc, sb[0][63:32], sb[0][31:0]);
                  void'(sb.pop_front());
               end else begin
                  void'(sb.pop_front());
               end
            end
            if (bus.pc_icache_ce && bus.icache_enable) begin
               sb.push_back({inst_of(exp_pc), exp_pc});
               exp_pc = exp_pc + 32'd4;
            end
         end
      end
   end

   // Resets the DUT and returns one step after release, with the DUT in IDLE.
   task automatic apply_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      cache_on = 1'b0;
      latency = 0;
      bus.deq_ready = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = 32'h0;
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      cache_on = 1'b0;
      latency = 0;
      bus.deq_ready = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      tests_run++;
      if ({bus.pc_icache_ce, bus.deq_valid, bus.queue_count} !== 6'b0 ||
          bus.icache_addr !== 32'h0 || bus.deq_inst !== 32'h0 || bus.deq_pc !== 32'h0) begin
         tests_failed++;
         $display("[TB] FAIL reset_state: ce=%b addr=%h valid=%b inst=%h pc=%h count=%0d required all zero",
                  bus.pc_icache_ce, bus.icache_addr, bus.deq_valid, bus.deq_inst, bus.deq_pc, bus.queue_count);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      tests_run++;
      if (bus.pc_icache_ce !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL idle_ce: got %b expected 0", bus.pc_icache_ce);
      end
   endtask

   task automatic test_stream();
      apply_reset();
      cache_on = 1'b1;
      bus.deq_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk);
         @(negedge clk);
         tests_run++;
         if (bus.pc_icache_ce !== 1'b1 || bus.icache_addr !== 32'(4 * k)) begin
            tests_failed++;
            $display("[TB] FAIL stream_addr: ce=%b addr=%h expected ce=1 addr=%h",
                     bus.pc_icache_ce, bus.icache_addr, 32'(4 * k));
         end
         if (k > 0) begin
            tests_run++;
            if (bus.deq_valid !== 1'b1 || bus.deq_pc !== 32'(4 * (k - 1)) ||
                bus.deq_inst !== inst_of(32'(4 * (k - 1))) || bus.queue_count !== 4'd1) begin
               tests_failed++;
               $display("[TB] FAIL stream_deq: valid=%b pc=%h inst=%h count=%0d expected pc=%h count=1",
                        bus.deq_valid, bus.deq_pc, bus.deq_inst, bus.queue_count, 32'(4 * (k - 1)));
            end
         end
      end
   endtask

   task automatic test_full();
      apply_reset();
      cache_on = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk);
         @(negedge clk);
         tests_run++;
         if (bus.queue_count !== 4'(k) || bus.icache_addr !== 32'(4 * k)) begin
            tests_failed++;
            $display("[TB] FAIL fill: count=%0d addr=%h expected count=%0d addr=%h",
                     bus.queue_count, bus.icache_addr, k, 32'(4 * k));
         end
      end
      @(posedge clk);
      @(negedge clk);
      tests_run++;
      if (bus.queue_count !== 4'd8 || bus.pc_icache_ce !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL full_stall: count=%0d ce=%b expected count=8 ce=0",
                  bus.queue_count, bus.pc_icache_ce);
      end
      @(posedge clk); #1;
      bus.deq_ready = 1'b1;
      @(negedge clk);
      tests_run++;
      if (bus.pc_icache_ce !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL stall_hold: ce=%b expected 0", bus.pc_icache_ce);
      end
      @(posedge clk); #1;
      bus.deq_ready = 1'b0;
      @(negedge clk);
      tests_run++;
      if (bus.pc_icache_ce !== 1'b1 || bus.icache_addr !== 32'h20 || bus.queue_count !== 4'd7) begin
         tests_failed++;
         $display("[TB] FAIL stall_release: ce=%b addr=%h count=%0d expected ce=1 addr=20 count=7",
                  bus.pc_icache_ce, bus.icache_addr, bus.queue_count);
      end
   endtask

   task automatic test_latency();
      apply_reset();
      cache_on = 1'b1;
      latency = 3;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            tests_run++;
            if (bus.pc_icache_ce !== 1'b1 || bus.icache_addr !== 32'(4 * r) ||
                bus.queue_count !== 4'(r)) begin
               tests_failed++;
               $display("[TB] FAIL latency_hold: ce=%b addr=%h count=%0d expected ce=1 addr=%h count=%0d",
                        bus.pc_icache_ce, bus.icache_addr, bus.queue_count, 32'(4 * r), r);
            end
         end
      end
   endtask

   task automatic test_redirect();
      apply_reset();
      cache_on = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         @(negedge clk);
      end
      @(posedge clk); #1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h100;
      @(negedge clk);
      tests_run++;
      if (bus.queue_count !== 4'd5 || bus.pc_icache_ce !== 1'b1 || bus.icache_enable !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL redirect_setup: count=%0d ce=%b expected count=5 ce=1",
                  bus.queue_count, bus.pc_icache_ce);
      end
      @(posedge clk); #1;
      bus.redirect_valid = 1'b0;
      bus.deq_ready = 1'b1;
      @(negedge clk);
      tests_run++;
      if (bus.queue_count !== 4'd0 || bus.deq_valid !== 1'b0 ||
          bus.pc_icache_ce !== 1'b1 || bus.icache_addr !== 32'h100) begin
         tests_failed++;
         $display("[TB] FAIL redirect_flush: count=%0d valid=%b ce=%b addr=%h expected 0/0/1/100",
                  bus.queue_count, bus.deq_valid, bus.pc_icache_ce, bus.icache_addr);
      end
      @(posedge clk);
      @(negedge clk);
      tests_run++;
      if (bus.deq_valid !== 1'b1 || bus.deq_pc !== 32'h100 ||
          bus.deq_inst !== inst_of(32'h100) || bus.icache_addr !== 32'h104) begin
         tests_failed++;
         $display("[TB] FAIL redirect_target: valid=%b pc=%h inst=%h addr=%h expected pc=100 addr=104",
                  bus.deq_valid, bus.deq_pc, bus.deq_inst, bus.icache_addr);
      end
      @(posedge clk); #1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h200;
      @(posedge clk); #1;
      bus.redirect_pc = 32'h300;
      @(posedge clk); #1;
      bus.redirect_valid = 1'b0;
      @(negedge clk);
      tests_run++;
      if (bus.icache_addr !== 32'h300 || bus.queue_count !== 4'd0) begin
         tests_failed++;
         $display("[TB] FAIL redirect_last_wins: addr=%h count=%0d expected addr=300 count=0",
                  bus.icache_addr, bus.queue_count);
      end
   endtask

   task automatic test_wrap();
      apply_reset();
      cache_on = 1'b1;
      for (int k = 0; k < 7; k++) begin
         @(posedge clk);
         @(negedge clk);
      end
      @(posedge clk); #1;
      bus.deq_ready = 1'b1;
      for (int j = 0; j < 11; j++) begin
         @(negedge clk);
         tests_run++;
         if (bus.queue_count !== 4'd7 || bus.deq_pc !== 32'(4 * j) ||
             bus.deq_inst !== inst_of(32'(4 * j))) begin
            tests_failed++;
            $display("[TB] FAIL wrap_order: count=%0d pc=%h inst=%h expected count=7 pc=%h",
                     bus.queue_count, bus.deq_pc, bus.deq_inst, 32'(4 * j));
         end
         @(posedge clk);
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      cache_on = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         @(negedge clk);
      end
      #1;
      rst = 1'b0;
      #1;
      tests_run++;
      if (bus.pc_icache_ce !== 1'b0 || bus.icache_addr !== 32'h0 ||
          bus.queue_count !== 4'd0 || bus.deq_valid !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_mid: ce=%b addr=%h count=%0d valid=%b expected all zero",
                  bus.pc_icache_ce, bus.icache_addr, bus.queue_count, bus.deq_valid);
      end
      @(posedge clk);
      @(negedge clk);
      tests_run++;
      if (bus.queue_count !== 4'd0 || bus.pc_icache_ce !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_hold: count=%0d ce=%b expected 0/0",
                  bus.queue_count, bus.pc_icache_ce);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
   endtask

   initial begin
      tests_run = 0;
      tests_failed = 0;
      rst = 1'b0;
      cache_on = 1'b0;
      latency = 0;
      bus.deq_ready = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = 32'h0;
      test_reset();
      test_stream();
      test_full();
      test_latency();
      test_redirect();
      test_wrap();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
